// File: rtl/simon_pkg.sv
// Shared SIMON constants, FSM encoding, rotate helpers and (N,M) parameter tables.
// The optional decrypt path is enabled by defining SIMON_DEC_EN.
package simon_pkg;

    localparam logic [61:0] Z_SEQ0 = {31'b1111101000100101011000011100110, 31'b1111101000100101011000011100110};
    localparam logic [61:0] Z_SEQ1 = {31'b1000111011111001001100001011010, 31'b1000111011111001001100001011010};
    localparam logic [61:0] Z_SEQ2 = {31'b1010111101110000001101001001100, 31'b0101000010001111110010110110011};
    localparam logic [61:0] Z_SEQ3 = {31'b1101101110101100011001011110000, 31'b0010010001010011100110100001111};
    localparam logic [61:0] Z_SEQ4 = {31'b1101000111100110101101100010000, 31'b0010111000011001010010011101111};
    // Bit 61 of each entry is z[0]; the sequence is consumed MSB first.
    localparam logic [4:0][61:0] Z_SEQ = {Z_SEQ4, Z_SEQ3, Z_SEQ2, Z_SEQ1, Z_SEQ0};

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        KEXP = 4'd1,
        RUN  = 4'd2,
        HOLD = 4'd3
    } state_e;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        return ((v << s) | (v >> (n - s))) & mask;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int s, input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        return ((v >> s) | (v << (n - s))) & mask;
    endfunction

    function automatic int simon_rounds(input int n, input int m);
        int r;
        case (n * 10 + m)
            164:     r = 32;
            243:     r = 36;
            244:     r = 36;
            323:     r = 42;
            324:     r = 44;
            482:     r = 52;
            483:     r = 54;
            642:     r = 68;
            643:     r = 69;
            644:     r = 72;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic int simon_zidx(input int n, input int m);
        int r;
        case (n * 10 + m)
            164, 243:      r = 0;
            244:           r = 1;
            323, 482, 642: r = 2;
            324, 483, 643: r = 3;
            644:           r = 4;
            default:       r = -1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/simon_keyexp.sv
// Round-key store with one-word-per-cycle SIMON key expansion.
// Words k0..k(M-1) are loaded in parallel; k(waddr) is derived from earlier words.
module simon_keyexp
    import simon_pkg::*;
#(
    parameter int N  = 64,
    parameter int M  = 3,
    parameter int T  = 69,
    parameter int Z  = 3,
    parameter int AW = $clog2(T)
) (
    input  logic                clk,
    input  logic                load_i,
    input  logic [M-1:0][N-1:0] key_i,
    input  logic                exp_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [N-1:0]        rkey_o
);

    localparam logic [61:0]  ZS = Z_SEQ[Z];
    localparam logic [N-1:0] KC = {{(N-2){1'b1}}, 2'b00};

    logic [N-1:0]  mem_q [T];
    logic [AW-1:0] ia, ib, ic;
    logic [6:0]    zi_raw, zi;
    logic [N-1:0]  tmp, knew;

    assign ia     = waddr_i - AW'(M);
    assign ib     = ia + AW'(1);
    assign ic     = waddr_i - AW'(1);
    assign zi_raw = 7'(ia);
    assign zi     = (zi_raw >= 7'd62) ? zi_raw - 7'd62 : zi_raw;

    always_comb begin
        tmp  = N'(rotr(64'(mem_q[ic]), 3, N));
        tmp  = tmp ^ ((M == 4) ? mem_q[ib] : '0);
        tmp  = tmp ^ N'(rotr(64'(tmp), 1, N));
        knew = KC ^ mem_q[ia] ^ tmp;
        knew[0] = knew[0] ^ ZS[6'(7'd61 - zi)];
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            for (int j = 0; j < M; j++) mem_q[j] <= key_i[j];
        end else if (exp_i) begin
            mem_q[waddr_i] <= knew;
        end
    end

    assign rkey_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_param_core.sv
// Iterative SIMON core: one round per clock, stored key schedule, separate output register.
// Define SIMON_DEC_EN to build the decrypt path (reverse key order and half swapping).
module simon_param_core
    import simon_pkg::*;
#(
    parameter int N  = 64,
    parameter int M  = 3,
    parameter int T  = 69,
    parameter int Co = 7,
    parameter int Z  = 3
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                newData,
    input  logic                newKey,
    input  logic                enc_dec,
    input  logic                readData,
    input  logic [1:0][N-1:0]   BLOCK,
    input  logic [M-1:0][N-1:0] KEY,
    output logic                loadData,
    output logic                loadKey,
    output logic                doneData,
    output logic                doneKey,
    output logic [1:0][N-1:0]   outData,
    output logic [3:0]          mode
);

    localparam int            AW   = $clog2(T);
    localparam logic [Co-1:0] LAST = Co'(T - 1);

    if (Co < $clog2(T + 1)) begin : g_co_chk
        $error("simon_param_core: Co too narrow for T");
    end
    if (T != simon_rounds(N, M) || Z != simon_zidx(N, M)) begin : g_tz_chk
        $error("simon_param_core: T/Z inconsistent with (N,M)");
    end

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
        return N'(rotl(64'(v), s, N));
    endfunction

    state_e            state_q, state_d;
    logic [Co-1:0]     cnt_q, cnt_d;
    logic              ld_q, ld_d, lk_q, lk_d, dd_q, dd_d, dk_q, dk_d;
    logic [1:0][N-1:0] out_q, out_d;
    logic [N-1:0]      x_q, y_q, rk, fx, xr;
    logic              cap, kload, kexp;
    logic [AW-1:0]     raddr;
    logic [1:0][N-1:0] blk_in, run_res, hold_res;

    assign fx = (rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2);
    assign xr = y_q ^ fx ^ rk;

`ifdef SIMON_DEC_EN
    logic dec_q;

    always_ff @(posedge clk or negedge nR) begin
        if (!nR)      dec_q <= 1'b0;
        else if (cap) dec_q <= ~enc_dec;
    end

    // Decryption runs the encrypt round on swapped halves with keys in reverse.
    assign raddr    = dec_q ? AW'(T - 1) - cnt_q[AW-1:0] : cnt_q[AW-1:0];
    assign blk_in   = enc_dec ? BLOCK : {BLOCK[0], BLOCK[1]};
    assign run_res  = dec_q ? {x_q, xr} : {xr, x_q};
    assign hold_res = dec_q ? {y_q, x_q} : {x_q, y_q};
`else
    logic unused_enc_dec;

    assign unused_enc_dec = enc_dec;
    assign raddr    = cnt_q[AW-1:0];
    assign blk_in   = BLOCK;
    assign run_res  = {xr, x_q};
    assign hold_res = {x_q, y_q};
`endif

    simon_keyexp #(.N(N), .M(M), .T(T), .Z(Z), .AW(AW)) u_keyexp (
        .clk     (clk),
        .load_i  (kload),
        .key_i   (KEY),
        .exp_i   (kexp),
        .waddr_i (cnt_q[AW-1:0]),
        .raddr_i (raddr),
        .rkey_o  (rk)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_d    = 1'b0;
        lk_d    = 1'b0;
        dd_d    = dd_q & ~readData;
        dk_d    = dk_q;
        out_d   = out_q;
        cap     = 1'b0;
        kload   = 1'b0;
        kexp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (newKey) begin
                    kload   = 1'b1;
                    lk_d    = 1'b1;
                    dk_d    = 1'b0;
                    cnt_d   = Co'(M);
                    state_d = KEXP;
                end else if (newData && dk_q) begin
                    cap     = 1'b1;
                    ld_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            KEXP: begin
                kexp = 1'b1;
                if (cnt_q == LAST) begin
                    dk_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + Co'(1);
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    // A result may overwrite outData only if it is free or being read now.
                    if (!dd_q || readData) begin
                        out_d   = run_res;
                        dd_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + Co'(1);
                end
            end
            HOLD: begin
                if (readData) begin
                    out_d   = hold_res;
                    dd_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ld_q    <= 1'b0;
            lk_q    <= 1'b0;
            dd_q    <= 1'b0;
            dk_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            lk_q    <= lk_d;
            dd_q    <= dd_d;
            dk_q    <= dk_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            x_q <= blk_in[1];
            y_q <= blk_in[0];
        end else if (state_q == RUN) begin
            x_q <= xr;
            y_q <= x_q;
        end
    end

    assign loadData = ld_q;
    assign loadKey  = lk_q;
    assign doneData = dd_q;
    assign doneKey  = dk_q;
    assign outData  = out_q;
    assign mode     = state_q;

endmodule

// File: tb/tb_simon_param_core.sv
// Directed bench for simon_param_core: SIMON128/192 and SIMON32/64 instances.
module tb_simon_param_core;

    localparam logic [191:0] KEY128 = 192'h1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
    localparam logic [127:0] PT128  = 128'h206572656874206E_6568772065626972;
    localparam logic [127:0] CT128  = 128'hC4AC61EFFCDC0D4F_6C9C8D6E2597B85B;
    localparam logic [61:0]  TB_Z3  = 62'b11011011101011000110010111100000010010001010011100110100001111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t_load = 0;

    logic              nR_a, newData_a, newKey_a, encdec_a, readData_a;
    logic [1:0][63:0]  BLOCK_a;
    logic [2:0][63:0]  KEY_a;
    logic              loadData_a, loadKey_a, doneData_a, doneKey_a;
    logic [1:0][63:0]  outData_a;
    logic [3:0]        mode_a;

    logic              nR_b, newData_b, newKey_b, encdec_b, readData_b;
    logic [1:0][15:0]  BLOCK_b;
    logic [3:0][15:0]  KEY_b;
    logic              loadData_b, loadKey_b, doneData_b, doneKey_b;
    logic [1:0][15:0]  outData_b;
    logic [3:0]        mode_b;

    int lk_cnt = 0;
    always @(posedge clk) if (loadKey_a) lk_cnt <= lk_cnt + 1;

    simon_param_core #(.N(64), .M(3), .T(69), .Co(7), .Z(3)) dut_a (
        .clk(clk), .nR(nR_a), .newData(newData_a), .newKey(newKey_a), .enc_dec(encdec_a),
        .readData(readData_a), .BLOCK(BLOCK_a), .KEY(KEY_a), .loadData(loadData_a),
        .loadKey(loadKey_a), .doneData(doneData_a), .doneKey(doneKey_a),
        .outData(outData_a), .mode(mode_a)
    );

    simon_param_core #(.N(16), .M(4), .T(32), .Co(6), .Z(0)) dut_b (
        .clk(clk), .nR(nR_b), .newData(newData_b), .newKey(newKey_b), .enc_dec(encdec_b),
        .readData(readData_b), .BLOCK(BLOCK_b), .KEY(KEY_b), .loadData(loadData_b),
        .loadKey(loadKey_b), .doneData(doneData_b), .doneKey(doneKey_b),
        .outData(outData_b), .mode(mode_b)
    );

    function automatic logic [127:0] ref_enc(input logic [191:0] key, input logic [127:0] pt);
        logic [63:0] k [69];
        logic [63:0] x, y, t, tmp;
        k[0] = key[63:0];
        k[1] = key[127:64];
        k[2] = key[191:128];
        for (int i = 0; i < 66; i++) begin
            tmp = {k[i+2][2:0], k[i+2][63:3]};
            tmp = tmp ^ {tmp[0], tmp[63:1]};
            k[i+3] = ~k[i] ^ tmp ^ {63'd0, TB_Z3[6'(61 - (i % 62))]} ^ 64'd3;
        end
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < 69; i++) begin
            t = x;
            x = y ^ (({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]}) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic a_load_key(input logic [191:0] key, output int lat, output bit ok);
        int c0;
        c0 = 0;
        lat = -1;
        ok = 1'b0;
        @(negedge clk);
        KEY_a = key;
        newKey_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (loadKey_a) begin c0 = cyc; ok = 1'b1; break; end
        end
        newKey_a = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk); #1;
                if (doneKey_a) begin lat = cyc - c0; ok = 1'b1; break; end
            end
        end
    endtask

    task automatic a_send(input logic [127:0] blk, input logic enc, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        BLOCK_a = blk;
        encdec_a = enc;
        newData_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (loadData_a) begin t_load = cyc; ok = 1'b1; break; end
        end
        newData_a = 1'b0;
    endtask

    task automatic a_wait_done(output int lat, output bit ok);
        ok = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (doneData_a) begin lat = cyc - t_load; ok = 1'b1; break; end
        end
    endtask

    task automatic a_read();
        @(negedge clk);
        readData_a = 1'b1;
        @(posedge clk); #1;
        readData_a = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({loadData_a, loadKey_a, doneData_a, doneKey_a, mode_a} !== 8'h00) begin
            errors++; $display("FAIL reset_flags_a: got %b expected 00000000", {loadData_a, loadKey_a, doneData_a, doneKey_a, mode_a});
        end
        checks++;
        if (outData_a !== 128'h0) begin
            errors++; $display("FAIL reset_out_a: got %h expected 0", outData_a);
        end
        checks++;
        if ({loadData_b, loadKey_b, doneData_b, doneKey_b, mode_b, outData_b} !== 40'h0) begin
            errors++; $display("FAIL reset_b: got %h expected 0", {loadData_b, loadKey_b, doneData_b, doneKey_b, mode_b, outData_b});
        end
        @(negedge clk);
        nR_a = 1'b1;
        nR_b = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mode_a !== 4'd0 || doneKey_a !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: mode %0d doneKey %b expected 0 0", mode_a, doneKey_a);
        end
    endtask

    task automatic test_enc128();
        int lat;
        bit ok;
        a_load_key(KEY128, lat, ok);
        checks++;
        if (!ok || lat != 66) begin
            errors++; $display("FAIL key_latency_128: ok %b latency %0d expected 66", ok, lat);
        end
        a_send(PT128, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL load_data_128: loadData never seen"); end
        @(posedge clk); #1;
        checks++;
        if (loadData_a !== 1'b0 || mode_a !== 4'd2) begin
            errors++; $display("FAIL load_pulse_128: loadData %b mode %0d expected 0 2", loadData_a, mode_a);
        end
        a_wait_done(lat, ok);
        checks++;
        if (!ok || lat != 69) begin
            errors++; $display("FAIL data_latency_128: ok %b latency %0d expected 69", ok, lat);
        end
        checks++;
        if (outData_a !== CT128) begin
            errors++; $display("FAIL enc_128: got %h expected %h", outData_a, CT128);
        end
        a_read();
        checks++;
        if (doneData_a !== 1'b0) begin
            errors++; $display("FAIL read_clears_done: got %b expected 0", doneData_a);
        end
    endtask

`ifdef SIMON_DEC_EN
    task automatic test_decrypt();
        int lat, lk0;
        bit ok;
        lk0 = lk_cnt;
        a_send(CT128, 1'b0, ok);
        a_wait_done(lat, ok);
        checks++;
        if (!ok || outData_a !== PT128) begin
            errors++; $display("FAIL dec_128: ok %b got %h expected %h", ok, outData_a, PT128);
        end
        checks++;
        if (doneKey_a !== 1'b1 || lk_cnt != lk0) begin
            errors++; $display("FAIL dec_no_rekey: doneKey %b loadKey pulses %0d expected 1 0", doneKey_a, lk_cnt - lk0);
        end
        a_read();
        encdec_a = 1'b1;
    endtask
`endif

    task automatic test_3264();
        int c0, lat;
        bit ok;
        c0 = 0;
        lat = -1;
        ok = 1'b0;
        @(negedge clk);
        KEY_b = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
        newKey_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (loadKey_b) begin c0 = cyc; break; end
        end
        newKey_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (doneKey_b) begin lat = cyc - c0; break; end
        end
        checks++;
        if (lat != 28) begin
            errors++; $display("FAIL key_latency_3264: got %0d expected 28", lat);
        end
        @(negedge clk);
        BLOCK_b = {16'h6565, 16'h6877};
        newData_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (loadData_b) begin c0 = cyc; break; end
        end
        newData_b = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (doneData_b) begin lat = cyc - c0; ok = 1'b1; break; end
        end
        checks++;
        if (!ok || lat != 32) begin
            errors++; $display("FAIL data_latency_3264: ok %b latency %0d expected 32", ok, lat);
        end
        checks++;
        if (outData_b !== 32'hC69BE9BB) begin
            errors++; $display("FAIL enc_3264: got %h expected c69be9bb", outData_b);
        end
    endtask

    task automatic test_stream();
        logic [127:0] pts [5];
        logic [127:0] exp_ct [5];
        int lat;
        bit ok;
        pts[0] = PT128;
        pts[1] = 128'h0123456789ABCDEF_FEDCBA9876543210;
        pts[2] = 128'h0;
        pts[3] = 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF;
        pts[4] = 128'hDEADBEEFCAFEF00D_0011223344556677;
        for (int b = 0; b < 5; b++) exp_ct[b] = ref_enc(KEY128, pts[b]);
        a_send(pts[0], 1'b1, ok);
        a_wait_done(lat, ok);
        checks++;
        if (!ok || outData_a !== exp_ct[0]) begin
            errors++; $display("FAIL stream_blk0: ok %b got %h expected %h", ok, outData_a, exp_ct[0]);
        end
        for (int b = 1; b < 5; b++) begin
            a_send(pts[b], 1'b1, ok);
            ok = 1'b0;
            for (int i = 0; i < 80; i++) begin
                @(posedge clk); #1;
                if (mode_a == 4'd3) begin ok = 1'b1; break; end
            end
            checks++;
            if (!ok || doneData_a !== 1'b1 || outData_a !== exp_ct[b-1]) begin
                errors++; $display("FAIL stream_hold%0d: hold %b done %b out %h expected held %h", b, ok, doneData_a, outData_a, exp_ct[b-1]);
            end
            repeat (10) @(posedge clk);
            a_read();
            checks++;
            if (outData_a !== exp_ct[b] || doneData_a !== 1'b1 || mode_a !== 4'd0) begin
                errors++; $display("FAIL stream_blk%0d: out %h done %b mode %0d expected %h 1 0", b, outData_a, doneData_a, mode_a, exp_ct[b]);
            end
        end
        a_read();
        checks++;
        if (doneData_a !== 1'b0) begin
            errors++; $display("FAIL stream_final_read: doneData %b expected 0", doneData_a);
        end
    endtask

    task automatic test_priority();
        int lat;
        bit ok, early;
        early = 1'b0;
        ok = 1'b0;
        @(negedge clk);
        KEY_a = KEY128;
        BLOCK_a = PT128;
        encdec_a = 1'b1;
        newKey_a = 1'b1;
        newData_a = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (loadKey_a !== 1'b1 || loadData_a !== 1'b0) begin
            errors++; $display("FAIL prio_first: loadKey %b loadData %b expected 1 0", loadKey_a, loadData_a);
        end
        newKey_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (loadData_a) early = 1'b1;
            if (doneKey_a) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        checks++;
        if (!ok || early || loadData_a !== 1'b1) begin
            errors++; $display("FAIL prio_data_after_key: keydone %b early %b loadData %b expected 1 0 1", ok, early, loadData_a);
        end
        t_load = cyc;
        newData_a = 1'b0;
        a_wait_done(lat, ok);
        checks++;
        if (!ok || outData_a !== CT128) begin
            errors++; $display("FAIL prio_result: ok %b got %h expected %h", ok, outData_a, CT128);
        end
        a_read();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit ok, bad;
        bad = 1'b0;
        a_send(PT128, 1'b1, ok);
        repeat (20) @(posedge clk);
        #2;
        checks++;
        if (mode_a !== 4'd2) begin
            errors++; $display("FAIL mid_run_mode: got %0d expected 2", mode_a);
        end
        nR_a = 1'b0;
        #1;
        checks++;
        if ({loadData_a, loadKey_a, doneData_a, doneKey_a, mode_a} !== 8'h00 || outData_a !== 128'h0) begin
            errors++; $display("FAIL async_reset: flags %b out %h expected 0", {loadData_a, loadKey_a, doneData_a, doneKey_a, mode_a}, outData_a);
        end
        @(negedge clk);
        nR_a = 1'b1;
        BLOCK_a = PT128;
        newData_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (loadData_a || mode_a != 4'd0) bad = 1'b1;
        end
        newData_a = 1'b0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL data_ignored_no_key: loadData or mode changed, expected idle");
        end
        a_load_key(KEY128, lat, ok);
        a_send(PT128, 1'b1, ok);
        a_wait_done(lat, ok);
        checks++;
        if (!ok || outData_a !== CT128) begin
            errors++; $display("FAIL after_rekey: ok %b got %h expected %h", ok, outData_a, CT128);
        end
        a_read();
    endtask

    initial begin
        nR_a = 1'b0; newData_a = 1'b0; newKey_a = 1'b0; encdec_a = 1'b1; readData_a = 1'b0;
        BLOCK_a = '0; KEY_a = '0;
        nR_b = 1'b0; newData_b = 1'b0; newKey_b = 1'b0; encdec_b = 1'b1; readData_b = 1'b0;
        BLOCK_b = '0; KEY_b = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_enc128();
`ifdef SIMON_DEC_EN
        test_decrypt();
`endif
        test_3264();
        test_stream();
        test_priority();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simon_param_core.md
# simon_param_core

Parametrised iterative SIMON block-cipher core covering the full SIMON family (2N-bit block, MN-bit key) with one round per clock, a stored round-key schedule, and encrypt/decrypt selectable per block. It is the generalised successor of the fixed-size SIMON_128192 core. It keeps that core's newData/newKey/readData handshake so the existing benches and top levels drop in. It adds a round-key store, so a key is expanded once and reused for any number of blocks, and a separate output register, so the next block can run while the previous result awaits readData.

## Interface
- N, 64, word size in bits (16, 24, 32, 48, 64); block is 2N
- M, 3, key words (2, 3, 4)
- T, 69, round count for the (N,M) pair
- Co, 7, round/key counter width; must be ≥ clog2(T+1)
- Z, 3, z-sequence index (0..4) for the (N,M) pair

Ports:
- clk  in  1  clock, rising edge
- nR  in  1  reset, asynchronous, active-low
- newData  in  1  level request: BLOCK valid
- newKey  in  1  level request: KEY valid
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled at data capture
- readData  in  1  consumer has taken outData
- BLOCK  in  [1:0][N-1:0]  input block; [1] = x (upper), [0] = y
- KEY  in  [M-1:0][N-1:0]  key; [0] = k0
- loadData  out  1  one-cycle pulse: BLOCK captured
- loadKey  out  1  one-cycle pulse: KEY captured
- doneData  out  1  outData holds an unread result
- doneKey  out  1  round-key store valid
- outData  out  [1:0][N-1:0]  result register
- mode  out  4  FSM state: IDLE=0, KEXP=1, RUN=2, HOLD=3

## Operation
- Round function: f(x) = (S1 x & S8 x) ^ S2 x.
- Encrypt round: x' = y ^ f(x) ^ k_i, y' = x, with i = 0..T-1.
- Decrypt: swap halves, apply the encrypt round with k_(T-1) down to k_0, swap halves at output.
- Key expansion: k_(i+M) = c ^ z_Z[(i) mod 62] ^ k_i ^ tmp ^ S^-1 tmp, where tmp = S^-3 k_(i+M-1).
  - For M=4, tmp additionally ^= k_(i+1) before the S^-1 step.
  - c = 2^N − 4. All arithmetic is modulo 2^N, with rotations only.
- Round-key store: T × N registers, written in KEXP and read by the round counter in RUN.

FSM:
- IDLE:
  - newKey → capture KEY into k_0..k_(M-1), pulse loadKey, clear doneKey, go to KEXP.
  - Otherwise, newData && doneKey → capture BLOCK and enc_dec, pulse loadData, go to RUN.
  - newKey has priority when both requests are high.
- KEXP: one key word per cycle for k_M..k_(T-1). After the last word, set doneKey and go to IDLE.
- RUN: one round per cycle. After round T:
  - if doneData is low, or readData is high in that cycle, write outData, set doneData, go to IDLE;
  - otherwise go to HOLD.
- HOLD: keep the finished state. On readData, write outData, keep doneData high, go to IDLE.
- doneData clears on the edge after readData is sampled high, unless a new result is written on that same edge.
- newKey in RUN/HOLD is deferred until IDLE; the key store is never overwritten mid-block.
- newData while doneKey is low is ignored and held off.
- readData while doneData is low has no effect.
- Reset (asynchronous, any state): state=IDLE, all outputs 0, outData=0, doneKey=0 (key invalid), counters 0. Store contents need not be cleared.

## Timing
- loadData/loadKey: registered, high exactly one cycle, asserted by the edge that captures the input.
- Data latency: doneData rises T edges after the loadData-rising edge when the output register is free. For 128/192 that is 69 cycles.
- Key latency: doneKey rises T−M edges after the loadKey-rising edge.
- Back-to-back throughput: T+1 cycles per block.
- outData is stable while doneData is high.

## Configuration
- SIMON_DEC_EN:
  - Defined: decryption path and reverse key-read order are built; enc_dec is honoured.
  - Undefined: encrypt-only. enc_dec is ignored (treated as 1) and there is no swap logic.

## Structure
- Package simon_pkg holds:
  - the five 62-bit z-sequence constants;
  - the state enum (4-bit, encodings as above);
  - functions rotl/rotr (width N via parameterised class or fixed 64-bit masked);
  - a T/Z lookup function by (N,M) for parameter checks.
- Sub-module simon_keyexp: round-key store plus expansion datapath, with write/read-address ports. The core holds the FSM, data register and output register.
- Elaboration-time assertion: Co ≥ clog2(T+1), and T/Z consistent with (N,M).

## Test plan
- 128/192 encrypt:
  - Stimulus: KEY = {1716151413121110, 0F0E0D0C0B0A0908, 0706050403020100}, BLOCK = 206572656874206E_6568772065626972.
  - Response: outData = C4AC61EFFCDC0D4F_6C9C8D6E2597B85B; doneData rises 69 edges after loadData.
- 128/192 decrypt (SIMON_DEC_EN) of that ciphertext with the same key → original plaintext. No re-expansion: doneKey stays high and loadKey does not pulse.
- 32/64 (N=16, M=4, T=32, Z=0, Co=6):
  - Stimulus: KEY = {1918, 1110, 0908, 0100}, BLOCK = 6565_6877.
  - Response: outData = C69B_E9BB; doneKey rises 28 edges after loadKey.
- Five-block stream with readData delayed 10 cycles:
  - The second block completes into HOLD, mode=3.
  - On readData, outData updates to block 2 and doneData stays high.
  - All five ciphertexts match the reference model.
- newData and newKey raised together in IDLE → loadKey first; loadData only after doneKey.
- nR low mid-RUN → all outputs 0 immediately and doneKey=0. A following newData is ignored until a new key has been expanded.
